// File: rtl/commit_unit.sv
// In-order retirement stage: drains the ROB head, writes the register file,
// hands stores to the store buffer and raises a flush on branch mispredict.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   head_*               ROB head entry (valid, ready, type, dest, value,
//                        branch outcome, ROB tag)
//   rd_en                dequeue the ROB head this cycle
//   rf_we/waddr/wdata    register file write port
//   rf_clr_tag           ROB tag to clear in the register-status table
//   st_commit_valid/tag  store commit request to the store buffer
//   st_commit_ready      store buffer accepts the commit
//   flush                one-cycle mispredict flush pulse
//   flush_busy           high while commit is stalled after a flush
//   retired_count        dequeued entries (wraps)
//   mispredict_count     mispredicts (saturates at 16'hFFFF)

module commit_unit #(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             head_valid,
    input  logic             head_ready,
    input  logic [1:0]       head_itype,
    input  logic [4:0]       head_dest_reg,
    input  logic [31:0]      head_value,
    input  logic             head_branch_result,
    input  logic [3:0]       head_rob_num,
    output logic             rd_en,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [3:0]       rf_clr_tag,
    output logic             st_commit_valid,
    output logic [3:0]       st_commit_tag,
    input  logic             st_commit_ready,
    output logic             flush,
    output logic             flush_busy,
    output logic [CNT_W-1:0] retired_count,
    output logic [15:0]      mispredict_count
);

    localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN,
        ST_WAIT,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [3:0]       st_tag_q, st_tag_d;
    logic [CNT_W-1:0] ret_q;
    logic [15:0]      mis_q;
    logic             mispredict;
    logic             head_ok;

    // Tag 0 marks an invalid entry even if valid/ready claim otherwise.
    assign head_ok = head_valid && head_ready && (head_rob_num != 4'd0);

    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        st_tag_d        = st_tag_q;
        mispredict      = 1'b0;
        rd_en           = 1'b0;
        rf_we           = 1'b0;
        rf_waddr        = 5'd0;
        rf_wdata        = 32'd0;
        rf_clr_tag      = 4'd0;
        st_commit_valid = 1'b0;
        st_commit_tag   = 4'd0;
        flush           = 1'b0;
        flush_busy      = 1'b0;

        // Gating on reset keeps every strobe low for the whole reset window,
        // not just after the first edge.
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (head_ok) begin
                        if (head_itype[1]) begin
                            rd_en      = 1'b1;
                            rf_we      = (head_dest_reg != 5'd0);
                            rf_waddr   = head_dest_reg;
                            rf_wdata   = head_value;
                            rf_clr_tag = head_rob_num;
                        end else if (head_itype[0]) begin
                            st_commit_valid = 1'b1;
                            st_commit_tag   = head_rob_num;
                            st_tag_d        = head_rob_num;
                            if (st_commit_ready) begin
                                rd_en = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end else begin
                            rd_en = 1'b1;
                            if (head_branch_result) begin
                                flush      = 1'b1;
                                mispredict = 1'b1;
                                fcnt_d     = FW'(FLUSH_CYCLES);
                                state_d    = FLUSH;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // Request is held with the captured tag until accepted.
                    st_commit_valid = 1'b1;
                    st_commit_tag   = st_tag_q;
                    if (st_commit_ready && head_valid) begin
                        rd_en   = 1'b1;
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    flush_busy = 1'b1;
                    fcnt_d     = fcnt_q - FW'(1);
                    if (fcnt_q <= FW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            fcnt_q   <= '0;
            st_tag_q <= 4'd0;
            ret_q    <= '0;
            mis_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            st_tag_q <= st_tag_d;
            if (rd_en) begin
                ret_q <= ret_q + CNT_W'(1);
            end
            if (mispredict && (mis_q != 16'hFFFF)) begin
                mis_q <= mis_q + 16'd1;
            end
        end
    end

    assign retired_count    = ret_q;
    assign mispredict_count = mis_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit.
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after.

module tb_commit_unit;

    logic        clk;
    logic        reset;
    logic        head_valid;
    logic        head_ready;
    logic [1:0]  head_itype;
    logic [4:0]  head_dest_reg;
    logic [31:0] head_value;
    logic        head_branch_result;
    logic [3:0]  head_rob_num;
    logic        rd_en;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_clr_tag;
    logic        st_commit_valid;
    logic [3:0]  st_commit_tag;
    logic        st_commit_ready;
    logic        flush;
    logic        flush_busy;
    logic [31:0] retired_count;
    logic [15:0] mispredict_count;

    int n_checks;
    int n_fail;

    commit_unit #(
        .FLUSH_CYCLES(3),
        .CNT_W(32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .head_valid        (head_valid),
        .head_ready        (head_ready),
        .head_itype        (head_itype),
        .head_dest_reg     (head_dest_reg),
        .head_value        (head_value),
        .head_branch_result(head_branch_result),
        .head_rob_num      (head_rob_num),
        .rd_en             (rd_en),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .rf_clr_tag        (rf_clr_tag),
        .st_commit_valid   (st_commit_valid),
        .st_commit_tag     (st_commit_tag),
        .st_commit_ready   (st_commit_ready),
        .flush             (flush),
        .flush_busy        (flush_busy),
        .retired_count     (retired_count),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_head(input logic v, input logic r,
                            input logic [1:0] it, input logic [4:0] d,
                            input logic [31:0] val, input logic br,
                            input logic [3:0] tag);
        head_valid         = v;
        head_ready         = r;
        head_itype         = it;
        head_dest_reg      = d;
        head_value         = val;
        head_branch_result = br;
        head_rob_num       = tag;
    endtask

    task automatic idle();
        set_head(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b0, 4'd0);
        st_commit_ready = 1'b0;
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_head(1'b1, 1'b1, 2'b10, 5'd9, 32'h1234_5678, 1'b0, 4'd2);
        st_commit_ready = 1'b1;
        #3;
        n_checks++;
        if (rd_en !== 1'b0 || rf_we !== 1'b0 || flush !== 1'b0 ||
            flush_busy !== 1'b0 || st_commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: rd=%b we=%b fl=%b fb=%b sv=%b want all 0",
                     rd_en, rf_we, flush, flush_busy, st_commit_valid);
        end
        n_checks++;
        if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || rf_clr_tag !== 4'd0 ||
            st_commit_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data: wa=%0d wd=%h ct=%0d st=%0d want 0",
                     rf_waddr, rf_wdata, rf_clr_tag, st_commit_tag);
        end
        cyc();
        n_checks++;
        if (retired_count !== 32'd0 || mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: ret=%0d mis=%0d want 0 0",
                     retired_count, mispredict_count);
        end
        idle();
        reset = 1'b0;
    endtask

    task automatic test_no_action();
        cyc();
        set_head(1'b1, 1'b1, 2'b10, 5'd4, 32'h1, 1'b0, 4'd0);
        #3;
        n_checks++;
        if (rd_en !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL tag0_noaction: rd=%b we=%b want 0 0", rd_en, rf_we);
        end
        cyc();
        set_head(1'b1, 1'b0, 2'b10, 5'd4, 32'h1, 1'b0, 4'd4);
        #3;
        n_checks++;
        if (rd_en !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL notready_noaction: rd=%b we=%b want 0 0", rd_en, rf_we);
        end
        cyc();
        set_head(1'b0, 1'b1, 2'b01, 5'd4, 32'h1, 1'b0, 4'd4);
        st_commit_ready = 1'b1;
        #3;
        n_checks++;
        if (rd_en !== 1'b0 || st_commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_noaction: rd=%b sv=%b want 0 0",
                     rd_en, st_commit_valid);
        end
        cyc();
        idle();
        n_checks++;
        if (retired_count !== 32'd0) begin
            n_fail++;
            $display("FAIL noaction_count: ret=%0d want 0", retired_count);
        end
    endtask

    task automatic test_reg_commit();
        set_head(1'b1, 1'b1, 2'b10, 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd3);
        #3;
        n_checks++;
        if (rd_en !== 1'b1 || rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_strobes: rd=%b we=%b want 1 1", rd_en, rf_we);
        end
        n_checks++;
        if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF ||
            rf_clr_tag !== 4'd3) begin
            n_fail++;
            $display("FAIL reg_data: wa=%0d wd=%h ct=%0d want 5 deadbeef 3",
                     rf_waddr, rf_wdata, rf_clr_tag);
        end
        n_checks++;
        if (retired_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reg_count_before: ret=%0d want 0", retired_count);
        end
        cyc();
        idle();
        n_checks++;
        if (retired_count !== 32'd1) begin
            n_fail++;
            $display("FAIL reg_count_after: ret=%0d want 1", retired_count);
        end
    endtask

    task automatic test_x0();
        set_head(1'b1, 1'b1, 2'b11, 5'd0, 32'hFFFF_0000, 1'b0, 4'd6);
        #3;
        n_checks++;
        if (rd_en !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_commit: rd=%b we=%b want 1 0", rd_en, rf_we);
        end
        cyc();
        idle();
        n_checks++;
        if (retired_count !== 32'd2) begin
            n_fail++;
            $display("FAIL x0_count: ret=%0d want 2", retired_count);
        end
    endtask

    task automatic test_store_backpressure();
        set_head(1'b1, 1'b1, 2'b01, 5'd0, 32'd0, 1'b0, 4'd7);
        for (int i = 0; i < 4; i++) begin
            st_commit_ready = (i == 3);
            #3;
            n_checks++;
            if (st_commit_valid !== 1'b1 || st_commit_tag !== 4'd7) begin
                n_fail++;
                $display("FAIL store_valid[%0d]: sv=%b tag=%0d want 1 7",
                         i, st_commit_valid, st_commit_tag);
            end
            n_checks++;
            if (rd_en !== (i == 3)) begin
                n_fail++;
                $display("FAIL store_rden[%0d]: rd=%b want %b",
                         i, rd_en, (i == 3));
            end
            cyc();
        end
        set_head(1'b1, 1'b1, 2'b10, 5'd8, 32'h55, 1'b0, 4'd8);
        st_commit_ready = 1'b0;
        #3;
        n_checks++;
        if (rd_en !== 1'b1 || st_commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_back_to_run: rd=%b sv=%b want 1 0",
                     rd_en, st_commit_valid);
        end
        cyc();
        idle();
        n_checks++;
        if (retired_count !== 32'd4) begin
            n_fail++;
            $display("FAIL store_count: ret=%0d want 4", retired_count);
        end
    endtask

    task automatic test_mispredict();
        set_head(1'b1, 1'b1, 2'b00, 5'd0, 32'd0, 1'b1, 4'd9);
        #3;
        n_checks++;
        if (flush !== 1'b1 || rd_en !== 1'b1 || flush_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mp_pulse: fl=%b rd=%b fb=%b want 1 1 0",
                     flush, rd_en, flush_busy);
        end
        cyc();
        set_head(1'b1, 1'b1, 2'b10, 5'd10, 32'hA, 1'b0, 4'd10);
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (flush_busy !== 1'b1 || rd_en !== 1'b0 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL mp_stall[%0d]: fb=%b rd=%b fl=%b want 1 0 0",
                         i, flush_busy, rd_en, flush);
            end
            cyc();
        end
        #3;
        n_checks++;
        if (rd_en !== 1'b1 || rf_we !== 1'b1 || flush_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mp_resume: rd=%b we=%b fb=%b want 1 1 0",
                     rd_en, rf_we, flush_busy);
        end
        n_checks++;
        if (mispredict_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mp_count: mis=%0d want 1", mispredict_count);
        end
        cyc();
        idle();
        n_checks++;
        if (retired_count !== 32'd6) begin
            n_fail++;
            $display("FAIL mp_retired: ret=%0d want 6", retired_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            unique case (i)
                0: set_head(1'b1, 1'b1, 2'b00, 5'd0, 32'd0, 1'b0, 4'd1);
                1: set_head(1'b1, 1'b1, 2'b10, 5'd1, 32'h11, 1'b0, 4'd2);
                2: set_head(1'b1, 1'b1, 2'b11, 5'd2, 32'h22, 1'b0, 4'd3);
                default: set_head(1'b1, 1'b1, 2'b01, 5'd0, 32'd0, 1'b0, 4'd4);
            endcase
            st_commit_ready = (i == 3);
            #3;
            n_checks++;
            if (rd_en !== 1'b1 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b[%0d]: rd=%b fl=%b want 1 0", i, rd_en, flush);
            end
            cyc();
        end
        idle();
        n_checks++;
        if (retired_count !== 32'd4 || mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_count: ret=%0d mis=%0d want 4 0",
                     retired_count, mispredict_count);
        end
    endtask

    task automatic test_async_reset();
        set_head(1'b1, 1'b1, 2'b01, 5'd0, 32'd0, 1'b0, 4'd12);
        st_commit_ready = 1'b0;
        cyc();
        #1;
        n_checks++;
        if (st_commit_valid !== 1'b1 || st_commit_tag !== 4'd12 ||
            rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_in_wait: sv=%b tag=%0d rd=%b want 1 12 0",
                     st_commit_valid, st_commit_tag, rd_en);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (st_commit_valid !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_strobes: sv=%b rd=%b want 0 0",
                     st_commit_valid, rd_en);
        end
        n_checks++;
        if (retired_count !== 32'd0 || mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_counters: ret=%0d mis=%0d want 0 0",
                     retired_count, mispredict_count);
        end
        idle();
        #1;
        reset = 1'b0;
        cyc();
        set_head(1'b1, 1'b1, 2'b10, 5'd13, 32'h13, 1'b0, 4'd13);
        #3;
        n_checks++;
        if (rd_en !== 1'b1 || rf_we !== 1'b1 || st_commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_run_after: rd=%b we=%b sv=%b want 1 1 0",
                     rd_en, rf_we, st_commit_valid);
        end
        cyc();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        test_reset();
        test_no_action();
        test_reg_commit();
        test_x0();
        test_store_backpressure();
        test_mispredict();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
